ofdm_frame_sched: RTL

//  Frame scheduler between the LFSR byte source and the 16QAM mapper/IFFT chain.
//  On start it emits PREAMBLE_SYMS fixed-pattern symbols, then num_syms payload symbols pulled from the source.

---
 rtl/ofdm_pkg.sv | 23 ++
 rtl/ofdm_frame_sched_if.sv | 26 ++
 rtl/ofdm_out_stage.sv | 54 +++++
 rtl/ofdm_frame_sched.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/ofdm_pkg.sv
// Shared types and defaults for the OFDM frame scheduler.
// State encoding, byte width and a counter-width helper.
package ofdm_pkg;

    localparam int BYTE_W            = 8;
    localparam int DEF_BYTES_PER_SYM = 4;
    localparam int DEF_PREAMBLE_SYMS = 2;
    localparam int DEF_GAP_CYCLES    = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_PAY  = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Bits needed to hold 0..max_val, never less than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ofdm_frame_sched_if.sv
// Byte-stream bundle of the scheduler: source side in, mapper side out.
// A byte moves on a cycle where valid && ready; valid never waits on ready, and once
// raised it holds with stable data/markers until the transfer happens.
interface ofdm_frame_sched_if;
    import ofdm_pkg::*;

    logic [BYTE_W-1:0] src_data;
    logic              src_valid;
    logic              src_ready;
    logic [BYTE_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_sos;
    logic              m_eof;

    modport master (
        input  src_data, src_valid, m_ready,
        output src_ready, m_data, m_valid, m_sos, m_eof
    );

    modport slave (
        output src_data, src_valid, m_ready,
        input  src_ready, m_data, m_valid, m_sos, m_eof
    );

endinterface

// File: rtl/ofdm_out_stage.sv
// Single-entry output register carrying {data, sos, eof} with valid/ready and flush.
// The caller only asserts i_load while o_can_load is high.
module ofdm_out_stage
    import ofdm_pkg::*;
(
    input  logic              aclk,
    input  logic              reset,
    input  logic              i_flush,
    input  logic              i_load,
    input  logic [BYTE_W-1:0] i_data,
    input  logic              i_sos,
    input  logic              i_eof,
    input  logic              i_ready,
    output logic [BYTE_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_sos,
    output logic              o_eof,
    output logic              o_can_load
);

    logic [BYTE_W-1:0] r_data;
    logic              r_valid;
    logic              r_sos;
    logic              r_eof;

    assign o_can_load = !r_valid || i_ready;

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_sos   <= 1'b0;
            r_eof   <= 1'b0;
        end else if (i_flush) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_sos   <= 1'b0;
            r_eof   <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
            r_sos   <= i_sos;
            r_eof   <= i_eof;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_sos   = r_sos;
    assign o_eof   = r_eof;

endmodule

// File: rtl/ofdm_frame_sched.sv
// Frame scheduler: preamble symbols, then payload symbols from the byte source,
// each symbol followed by an idle gap (except the last) so the IFFT/CP chain can drain.
module ofdm_frame_sched
    import ofdm_pkg::*;
#(
    parameter int                BYTES_PER_SYM = DEF_BYTES_PER_SYM,
    parameter int                PREAMBLE_SYMS = DEF_PREAMBLE_SYMS,
    parameter logic [BYTE_W-1:0] PREAMBLE_BYTE = 8'hA5,
    parameter int                GAP_CYCLES    = DEF_GAP_CYCLES,
    parameter int                SYM_W         = 8
) (
    input  logic               aclk,
    input  logic               reset,
    input  logic               start,
    input  logic [SYM_W-1:0]   num_syms,
    input  logic               abort,
    ofdm_frame_sched_if.master bus,
    output logic               busy,
    output logic               done,
    output logic [SYM_W-1:0]   sym_idx,
    output state_t             dbg_state
);

    localparam int BC_W = cnt_w(BYTES_PER_SYM);
    localparam int GC_W = cnt_w(GAP_CYCLES);
    localparam int PC_W = cnt_w(PREAMBLE_SYMS);
    localparam logic [BC_W-1:0] BPS_C     = BC_W'(BYTES_PER_SYM);
    localparam logic [BC_W-1:0] BYTE_LAST = BC_W'(BYTES_PER_SYM - 1);
    localparam logic [GC_W-1:0] GAP_LAST  = GC_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam logic [PC_W-1:0] PRE_C     = PC_W'(PREAMBLE_SYMS);
    localparam logic [PC_W-1:0] PRE_LAST  = PC_W'((PREAMBLE_SYMS == 0) ? 0 : PREAMBLE_SYMS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [BC_W-1:0]   r_byte_cnt;
    logic [GC_W-1:0]   r_gap_cnt;
    logic [PC_W-1:0]   r_pre_cnt;
    logic [SYM_W-1:0]  r_sym_idx;
    logic [SYM_W-1:0]  r_num_syms;

    logic              w_can_load, w_load, w_src_ready, w_sos, w_eof, w_done;
    logic              w_abort, w_start, w_sym_full, w_out_fire, w_sym_end;
    logic              w_last_byte, w_pre_last, w_pay_last;
    logic [BYTE_W-1:0] w_load_data;

    assign w_abort     = abort && (r_state != ST_IDLE);
    assign w_start     = start && !abort && (r_state == ST_IDLE);
    assign w_sym_full  = (r_byte_cnt == BPS_C);
    assign w_out_fire  = bus.m_valid && bus.m_ready;
    assign w_last_byte = (r_byte_cnt == BYTE_LAST);
    assign w_pre_last  = (r_pre_cnt == PRE_LAST);
    assign w_pay_last  = (r_sym_idx == (r_num_syms - SYM_W'(1)));
    assign w_sos       = (r_byte_cnt == '0);

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_src_ready = 1'b0;
        w_load      = 1'b0;
        w_load_data = PREAMBLE_BYTE;
        w_eof       = 1'b0;
        w_sym_end   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    if (PREAMBLE_SYMS > 0)   w_state_nxt = ST_PRE;
                    else if (num_syms != '0) w_state_nxt = ST_PAY;
                    else                     w_state_nxt = ST_DONE;
                end
            end
            ST_PRE: begin
                w_load = !w_sym_full && w_can_load;
                w_eof  = w_last_byte && w_pre_last && (r_num_syms == '0);
                // A symbol ends only once its last byte has left the output register.
                if (w_sym_full && w_out_fire) begin
                    w_sym_end = 1'b1;
                    if (w_pre_last && (r_num_syms == '0)) w_state_nxt = ST_DONE;
                    else if (GAP_CYCLES > 0)             w_state_nxt = ST_GAP;
                    else if (w_pre_last)                 w_state_nxt = ST_PAY;
                    else                                 w_state_nxt = ST_PRE;
                end
            end
            ST_PAY: begin
                w_src_ready = !w_sym_full && w_can_load;
                w_load      = w_src_ready && bus.src_valid;
                w_load_data = bus.src_data;
                w_eof       = w_last_byte && w_pay_last;
                if (w_sym_full && w_out_fire) begin
                    w_sym_end = 1'b1;
                    if (w_pay_last)          w_state_nxt = ST_DONE;
                    else if (GAP_CYCLES > 0) w_state_nxt = ST_GAP;
                    else                     w_state_nxt = ST_PAY;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST)
                    w_state_nxt = (r_pre_cnt != PRE_C) ? ST_PRE : ST_PAY;
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
            w_src_ready = 1'b0;
            w_load      = 1'b0;
            w_done      = 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            r_byte_cnt <= '0;
            r_gap_cnt  <= '0;
            r_pre_cnt  <= '0;
            r_sym_idx  <= '0;
            r_num_syms <= '0;
        end else if (w_abort) begin
            r_byte_cnt <= '0;
            r_gap_cnt  <= '0;
            r_pre_cnt  <= '0;
            r_sym_idx  <= '0;
            r_num_syms <= '0;
        end else begin
            if (w_start) begin
                r_num_syms <= num_syms;
                r_sym_idx  <= '0;
                r_byte_cnt <= '0;
                r_pre_cnt  <= '0;
                r_gap_cnt  <= '0;
            end
            if (w_load) r_byte_cnt <= r_byte_cnt + BC_W'(1);
            if (w_sym_end) begin
                r_byte_cnt <= '0;
                if (r_state == ST_PRE) r_pre_cnt <= r_pre_cnt + PC_W'(1);
                else                   r_sym_idx <= r_sym_idx + SYM_W'(1);
            end
            if (r_state == ST_GAP)
                r_gap_cnt <= (r_gap_cnt == GAP_LAST) ? '0 : r_gap_cnt + GC_W'(1);
        end
    end

    ofdm_out_stage u_out (
        .aclk       (aclk),
        .reset      (reset),
        .i_flush    (w_abort),
        .i_load     (w_load),
        .i_data     (w_load_data),
        .i_sos      (w_sos),
        .i_eof      (w_eof),
        .i_ready    (bus.m_ready),
        .o_data     (bus.m_data),
        .o_valid    (bus.m_valid),
        .o_sos      (bus.m_sos),
        .o_eof      (bus.m_eof),
        .o_can_load (w_can_load)
    );

    assign bus.src_ready = w_src_ready;
    assign busy          = (r_state != ST_IDLE);
    assign done          = w_done;
    assign sym_idx       = r_sym_idx;
    assign dbg_state     = r_state;

endmodule
